dg0045_rom_responder: RTL

Program-ROM responder for the DG0045 4-bit core: the memory end of the core's multiplexed fetch interface. Each 8-clock machine cycle it drives the half-select line (`pc_mux`), captures the two 5-bit halves of the 10-bit program counter from `pc_hl`, and returns the addressed instruction byte on `rom_data` in time for the core's fetch latch. It holds a 1024×8 image loaded through a byte-stream port. Until loading completes it presents NOP (8'h00).

---
 rtl/dg0045_rom_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/dg0045_rom_responder.sv
// Program-ROM responder for the DG0045 core: phase-locked PC half capture,
// asynchronous ROM read in the ph-3 window, and a byte-stream image loader.
module dg0045_rom_responder #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned PHASE_OFFSET = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] pc_hl,
    output logic       pc_mux,
    output logic [7:0] rom_data,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       ld_done
);

    localparam int unsigned HALF_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [PH_W-1:0]   PH_HI    = 3'd2;
    localparam logic [PH_W-1:0]   PH_RD    = 3'd3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_nxt;
    logic [HALF_W-1:0] hi_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_accept;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_byte;

    logic [DATA_W-1:0] mem [DEPTH];

    assign ph_nxt = ph + PH_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a start pulse always wins over a concurrent byte
    always_comb begin
        state_nxt = state;
        ld_accept = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) state_nxt = LOAD;
            end
            LOAD: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                end else if (ld_valid && ld_ready) begin
                    ld_accept = 1'b1;
                    if (ld_ptr == PTR_LAST) state_nxt = RUN;
                end
            end
            RUN: begin
                if (ld_start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Phase counter, half capture, fetch hold and loader bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph       <= PH_W'(PHASE_OFFSET);
            pc_mux   <= 1'b1;
            hi_q     <= '0;
            data_q   <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_ptr   <= '0;
        end else begin
            ph       <= ph_nxt;
            pc_mux   <= (ph_nxt != PH_RD);
            ld_ready <= (state_nxt == LOAD) && (ph_nxt != PH_HI) && (ph_nxt != PH_RD);
            if (ph == PH_HI) hi_q <= pc_hl;
            if (ph == PH_RD) data_q <= rd_byte;
            if (ld_start) begin
                ld_ptr  <= '0;
                ld_done <= 1'b0;
            end else if (ld_accept) begin
                ld_ptr <= ld_ptr + ADDR_W'(1);
                if (ld_ptr == PTR_LAST) ld_done <= 1'b1;
            end
        end
    end

    // Image storage; contents survive reset
    always_ff @(posedge clk) begin
        if (ld_accept) mem[ld_ptr] <= ld_data;
    end

    // Live ph-3 read path into the core's fetch latch; held value elsewhere
    assign rd_addr  = ADDR_W'({hi_q, pc_hl});
    assign rd_byte  = (state == RUN) ? mem[rd_addr] : 8'h00;
    assign rom_data = (ph == PH_RD) ? rd_byte : data_q;

endmodule
